mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Back end of the ID/EX-style pipeline buffer: consumes the R/W/demux/WE/WA bundle plus the ALU result.
//  Performs the data-memory access over a req/ack handshake.
//  Retires the instruction by driving the register-file write port.
//  Sits between the execute stage and the register file.
//  Stalls upstream through o_ready while a memory access is outstanding.
// PARAMETERS
//  DATA_W      32  width of ALU result, store data, memory data, RF write data
//  RA_W        5   register-file address width
//  TIMEOUT_CYC 16  memory-ack watchdog limit in cycles; used only with MEM_TIMEOUT_EN
// PORTS
//  CLK         in  1       clock, rising edge
//  RST         in  1       synchronous reset, active-high
//  i_valid     in  1       input bundle valid
//  o_ready     out 1       stage can accept a bundle this cycle
//  i_R         in  1       memory read
//  i_W         in  1       memory write
//  i_demux     in  1       writeback source: 1 = memory read data, 0 = i_res
//  i_WE        in  1       register-file write enable
//  i_WA        in  RA_W    register-file write address
//  i_res       in  DATA_W  ALU result; also the memory address
//  i_DR2       in  DATA_W  store data
//  o_mem_req   out 1       memory request, held until ack
//  o_mem_we    out 1       1 = write, 0 = read
//  o_mem_addr  out DATA_W  memory address
//  o_mem_wdata out DATA_W  memory write data
//  i_mem_ack   in  1       memory acknowledge; sampled only while o_mem_req=1
//  i_mem_rdata in  DATA_W  read data; valid in the ack cycle
//  o_rf_WE     out 1       RF write strobe, one-cycle pulse
//  o_rf_WA     out RA_W    RF write address
//  o_rf_WD     out DATA_W  RF write data
//  o_err       out 1       memory-timeout pulse; tied 0 when MEM_TIMEOUT_EN is undefined
// BEHAVIOUR
//  - One clock CLK; RST synchronous, active-high.
//  - RST: state=IDLE. All outputs 0 except o_ready=1.
//  - States: IDLE, MEM, WB. o_ready = (state==IDLE || state==WB). o_ready=0 in MEM.
//  - Accept at edge E when i_valid & o_ready. The bundle is latched at E.
//  - Accepted with i_R|i_W=0:
//    - next state WB; o_rf_WE=i_WE & (i_WA!=0), o_rf_WA=i_WA, o_rf_WD=i_res, all registered at E.
//    - Latency is 1 cycle.
//    - i_demux=1 with no memory op is treated as 0.
//  - Accepted with i_R|i_W=1:
//    - next state MEM; from E, o_mem_req=1, o_mem_we=i_W, o_mem_addr=i_res, o_mem_wdata=i_DR2.
//    - i_W has priority when i_R & i_W: the access is a write.
//  - MEM: all o_mem_* held stable until i_mem_ack is sampled high at edge A.
//    - At A: o_mem_req=0; o_rf_WE=WE & (WA!=0); o_rf_WA=WA; next state WB.
//    - At A: o_rf_WD = (demux & ~o_mem_we) ? i_mem_rdata : res.
//    - Ack in the first cycle of the request is legal. Minimum memory-op latency is 1 cycle after E.
//  - WB: the o_rf_* pulse is visible for exactly one cycle, then o_rf_WE=0.
//    - o_rf_WA/WD hold their last values.
//    - A new accept in WB behaves as in IDLE, so ALU ops sustain 1/cycle.
//  - i_mem_ack outside MEM is ignored.
//  - i_valid while o_ready=0 is not consumed; upstream must hold the bundle.
//  - RST mid-MEM: o_mem_req=0 after the RST edge; the access is abandoned with no RF write.
//  - Writes to WA=0 never assert o_rf_WE.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - A counter clears on MEM entry and increments each MEM cycle without ack.
//   - On reaching TIMEOUT_CYC: o_mem_req=0, o_err=1 for one cycle, no RF write, state=IDLE.
//   - An ack on the same edge as the timeout wins.
//  MEM_TIMEOUT_EN undefined: MEM waits indefinitely; o_err constant 0; no counter logic.
// TESTING
//  1. RST held 2 cycles -> o_ready=1; o_mem_req, o_rf_WE, o_err = 0.
//  2. ALU ops WA=3 res=0x11, then WA=4 res=0x22 on consecutive cycles:
//     -> o_rf_WE pulses 2 consecutive cycles (3/0x11, 4/0x22); o_ready stays 1.
//  3. Load R=1 demux=1 WE=1 WA=7 res=0x100; ack after 3 cycles with rdata=0xDEADBEEF:
//     -> o_mem_req=1, we=0, addr=0x100 for 3 cycles; o_ready=0; then o_rf_WE 1 cycle, 7/0xDEADBEEF.
//  4. Store W=1 res=0x40 DR2=0xCAFE WE=0; ack immediately:
//     -> one req cycle, we=1, wdata=0xCAFE; no o_rf_WE.
//     Also R=W=1 -> write performed.
//  5. ALU op WE=1 WA=0 -> no o_rf_WE.
//     Load, RST asserted while in MEM -> req drops; late ack ignored; no RF write.
//  6. MEM_TIMEOUT_EN with TIMEOUT_CYC=4, load never acked:
//     -> req drops after 4 cycles, o_err 1 pulse, o_ready=1.
//     Without the macro: req held for 50 cycles, o_err=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: req/ack data-memory access, then one-cycle register-file write pulse.
// Optional memory-ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
`ifdef MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_R,
    input  logic              i_W,
    input  logic              i_demux,
    input  logic              i_WE,
    input  logic [RA_W-1:0]   i_WA,
    input  logic [DATA_W-1:0] i_res,
    input  logic [DATA_W-1:0] i_DR2,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_rf_WE,
    output logic [RA_W-1:0]   o_rf_WA,
    output logic [DATA_W-1:0] o_rf_WD,
    output logic              o_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, WB = 2'd2} state_t;

    state_t              state, state_d;
    logic                ready_d;
    logic                mem_req_d, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_d, mem_wdata_d;
    logic                rf_we_d;
    logic [RA_W-1:0]     rf_wa_d;
    logic [DATA_W-1:0]   rf_wd_d;
    logic                demux_q, demux_d, we_q, we_d;
    logic [RA_W-1:0]     wa_q, wa_d;
    logic                accept;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign accept = i_valid & o_ready;

    // Next-state and next-output logic; memory address doubles as the saved ALU result.
    always_comb begin
        state_d     = state;
        mem_req_d   = o_mem_req;
        mem_we_d    = o_mem_we;
        mem_addr_d  = o_mem_addr;
        mem_wdata_d = o_mem_wdata;
        rf_we_d     = 1'b0;
        rf_wa_d     = o_rf_WA;
        rf_wd_d     = o_rf_WD;
        demux_d     = demux_q;
        we_d        = we_q;
        wa_d        = wa_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state)
            IDLE, WB: begin
                state_d = IDLE;
                if (accept) begin
                    if (i_R | i_W) begin
                        state_d     = MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_W;
                        mem_addr_d  = i_res;
                        mem_wdata_d = i_DR2;
                        demux_d     = i_demux;
                        we_d        = i_WE;
                        wa_d        = i_WA;
`ifdef MEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        state_d = WB;
                        rf_we_d = i_WE & (i_WA != '0);
                        rf_wa_d = i_WA;
                        rf_wd_d = i_res;
                    end
                end
            end
            MEM: begin
                if (i_mem_ack) begin
                    state_d   = WB;
                    mem_req_d = 1'b0;
                    rf_we_d   = we_q & (wa_q != '0);
                    rf_wa_d   = wa_q;
                    rf_wd_d   = (demux_q & ~o_mem_we) ? i_mem_rdata : o_mem_addr;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != MEM);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            o_ready     <= 1'b1;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_rf_WE     <= 1'b0;
            o_rf_WA     <= '0;
            o_rf_WD     <= '0;
            demux_q     <= 1'b0;
            we_q        <= 1'b0;
            wa_q        <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            o_ready     <= ready_d;
            o_mem_req   <= mem_req_d;
            o_mem_we    <= mem_we_d;
            o_mem_addr  <= mem_addr_d;
            o_mem_wdata <= mem_wdata_d;
            o_rf_WE     <= rf_we_d;
            o_rf_WA     <= rf_wa_d;
            o_rf_WD     <= rf_wd_d;
            demux_q     <= demux_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (define MEM_TIMEOUT_EN for the watchdog build).
module tb_mem_wb_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RA_W   = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic              i_valid, i_R, i_W, i_demux, i_WE, i_mem_ack;
    logic [RA_W-1:0]   i_WA;
    logic [DATA_W-1:0] i_res, i_DR2, i_mem_rdata;
    logic              o_ready, o_mem_req, o_mem_we, o_rf_WE, o_err;
    logic [DATA_W-1:0] o_mem_addr, o_mem_wdata, o_rf_WD;
    logic [RA_W-1:0]   o_rf_WA;

    int total = 0;
    int bad   = 0;

    mem_wb_stage #(
        .DATA_W(DATA_W),
        .RA_W(RA_W)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYC(4)
`endif
    ) dut (
        .CLK(CLK), .RST(RST), .i_valid(i_valid), .o_ready(o_ready),
        .i_R(i_R), .i_W(i_W), .i_demux(i_demux), .i_WE(i_WE), .i_WA(i_WA),
        .i_res(i_res), .i_DR2(i_DR2),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_rf_WE(o_rf_WE), .o_rf_WA(o_rf_WA), .o_rf_WD(o_rf_WD), .o_err(o_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bundle(input logic v, input logic r, input logic w, input logic dm,
                          input logic we, input logic [RA_W-1:0] wa,
                          input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] dr2);
        i_valid = v; i_R = r; i_W = w; i_demux = dm; i_WE = we; i_WA = wa;
        i_res = res; i_DR2 = dr2;
    endtask

    initial begin
        RST = 1'b1; i_mem_ack = 1'b0; i_mem_rdata = '0;
        bundle(0, 0, 0, 0, 0, '0, '0, '0);
        tick(); tick();
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_req", 64'(o_mem_req), 64'd0);
        check("rst_rfwe", 64'(o_rf_WE), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        RST = 1'b0;
        tick();

        // Back-to-back ALU ops
        bundle(1, 0, 0, 1, 1, 5'd3, 32'h11, 32'h0);
        tick();
        check("alu1_we", 64'(o_rf_WE), 64'd1);
        check("alu1_wa", 64'(o_rf_WA), 64'd3);
        check("alu1_wd", 64'(o_rf_WD), 64'h11);
        check("alu1_rdy", 64'(o_ready), 64'd1);
        bundle(1, 0, 0, 0, 1, 5'd4, 32'h22, 32'h0);
        tick();
        check("alu2_we", 64'(o_rf_WE), 64'd1);
        check("alu2_wa", 64'(o_rf_WA), 64'd4);
        check("alu2_wd", 64'(o_rf_WD), 64'h22);
        check("alu2_rdy", 64'(o_ready), 64'd1);
        bundle(0, 0, 0, 0, 0, '0, '0, '0);
        tick();
        check("alu_end_we", 64'(o_rf_WE), 64'd0);
        check("alu_hold_wd", 64'(o_rf_WD), 64'h22);

        // Ack outside MEM is ignored
        i_mem_ack = 1'b1;
        tick();
        check("idle_ack_req", 64'(o_mem_req), 64'd0);
        check("idle_ack_we", 64'(o_rf_WE), 64'd0);
        i_mem_ack = 1'b0;

        // Load with 3 request cycles
        bundle(1, 1, 0, 1, 1, 5'd7, 32'h100, 32'h0);
        tick();
        bundle(0, 0, 0, 0, 0, '0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            check("ld_req", 64'(o_mem_req), 64'd1);
            check("ld_we", 64'(o_mem_we), 64'd0);
            check("ld_addr", 64'(o_mem_addr), 64'h100);
            check("ld_rdy", 64'(o_ready), 64'd0);
            check("ld_rfwe", 64'(o_rf_WE), 64'd0);
            if (c == 2) begin
                i_mem_ack = 1'b1; i_mem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        check("ld_done_req", 64'(o_mem_req), 64'd0);
        check("ld_rfwe", 64'(o_rf_WE), 64'd1);
        check("ld_rfwa", 64'(o_rf_WA), 64'd7);
        check("ld_rfwd", 64'(o_rf_WD), 64'hDEADBEEF);
        check("ld_wb_rdy", 64'(o_ready), 64'd1);
        tick();
        check("ld_pulse_end", 64'(o_rf_WE), 64'd0);

        // Store with immediate ack
        bundle(1, 0, 1, 0, 0, 5'd5, 32'h40, 32'hCAFE);
        tick();
        bundle(0, 0, 0, 0, 0, '0, '0, '0);
        check("st_req", 64'(o_mem_req), 64'd1);
        check("st_we", 64'(o_mem_we), 64'd1);
        check("st_addr", 64'(o_mem_addr), 64'h40);
        check("st_wdata", 64'(o_mem_wdata), 64'hCAFE);
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        check("st_done_req", 64'(o_mem_req), 64'd0);
        check("st_rfwe", 64'(o_rf_WE), 64'd0);
        tick();

        // R and W together perform a write; writeback takes the result, not rdata
        bundle(1, 1, 1, 1, 1, 5'd9, 32'h80, 32'h1234);
        tick();
        bundle(0, 0, 0, 0, 0, '0, '0, '0);
        check("rw_we", 64'(o_mem_we), 64'd1);
        check("rw_wdata", 64'(o_mem_wdata), 64'h1234);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h5555;
        tick();
        i_mem_ack = 1'b0;
        check("rw_rfwe", 64'(o_rf_WE), 64'd1);
        check("rw_rfwd", 64'(o_rf_WD), 64'h80);
        tick();

        // Write to register 0 is suppressed
        bundle(1, 0, 0, 0, 1, 5'd0, 32'h77, 32'h0);
        tick();
        bundle(0, 0, 0, 0, 0, '0, '0, '0);
        check("wa0_rfwe", 64'(o_rf_WE), 64'd0);
        tick();

        // Reset while in MEM abandons the access
        bundle(1, 1, 0, 1, 1, 5'd6, 32'h200, 32'h0);
        tick();
        bundle(0, 0, 0, 0, 0, '0, '0, '0);
        check("rstmem_req", 64'(o_mem_req), 64'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rstmem_req_drop", 64'(o_mem_req), 64'd0);
        check("rstmem_rdy", 64'(o_ready), 64'd1);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD;
        tick();
        i_mem_ack = 1'b0;
        check("late_ack_req", 64'(o_mem_req), 64'd0);
        check("late_ack_rfwe", 64'(o_rf_WE), 64'd0);
        tick();

        // Load that is never acknowledged
        bundle(1, 1, 0, 1, 1, 5'd8, 32'h300, 32'h0);
        tick();
        bundle(0, 0, 0, 0, 0, '0, '0, '0);
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            check("to_req", 64'(o_mem_req), 64'd1);
            check("to_err_low", 64'(o_err), 64'd0);
            tick();
        end
        check("to_req_drop", 64'(o_mem_req), 64'd0);
        check("to_err", 64'(o_err), 64'd1);
        check("to_rdy", 64'(o_ready), 64'd1);
        check("to_rfwe", 64'(o_rf_WE), 64'd0);
        tick();
        check("to_err_pulse", 64'(o_err), 64'd0);
`else
        for (int c = 0; c < 50; c++) begin
            check("hold_req", 64'(o_mem_req), 64'd1);
            check("hold_err", 64'(o_err), 64'd0);
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("hold_rst_req", 64'(o_mem_req), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
